mac_argmax: RTL and testbench

Downstream classification stage for the MNIST datapath: consumes the stream of 22-bit signed neuron scores produced by the MAC/accumulate stage, one per output neuron, and reports the index and value of the largest score. Holds the result under a valid/ready handshake so the display/UART stage can take it at its own pace. One instance per network output layer.

---
 rtl/mac_argmax_if.sv | 27 ++
 rtl/mac_argmax.sv | 111 +++++++++++
 tb/tb_mac_argmax.sv | 274 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/mac_argmax_if.sv
// Handshake bundle between the score stream, the argmax block and the result consumer.
// Ports: start/in_valid/din/out_ready driven by master; in_ready/out_valid/class_idx/class_score/busy by slave.
// master = producer/consumer side (testbench or surrounding datapath), slave = mac_argmax.
interface mac_argmax_if #(
   parameter int DW    = 22,
   parameter int IDX_W = 4
);
   logic             start;
   logic             in_valid;
   logic             in_ready;
   logic [DW-1:0]    din;
   logic             out_valid;
   logic             out_ready;
   logic [IDX_W-1:0] class_idx;
   logic [DW-1:0]    class_score;
   logic             busy;

   modport master (
      output start, in_valid, din, out_ready,
      input  in_ready, out_valid, class_idx, class_score, busy
   );

   modport slave (
      input  start, in_valid, din, out_ready,
      output in_ready, out_valid, class_idx, class_score, busy
   );
endinterface

// File: rtl/mac_argmax.sv
// Purpose: tracks the largest signed score over N_CLASSES beats and reports its index and value.
// Latency: result valid the cycle after the last beat is accepted; one beat per cycle while collecting.
// Backpressure: result held with out_valid until out_ready; no new beats accepted until consumed.
// Ports: clk, rst (sync, active-low), bus (mac_argmax_if.slave: start, in_valid/in_ready/din,
//        out_valid/out_ready/class_idx/class_score, busy).
module mac_argmax #(
   parameter int N_CLASSES = 10,
   parameter int DW        = 22,
   parameter int IDX_W     = 4
) (
   input logic         clk,
   input logic         rst,
   mac_argmax_if.slave bus
);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      COLLECT = 2'd1,
      DONE    = 2'd2
   } state_t;

   localparam logic [IDX_W-1:0] LAST = IDX_W'(N_CLASSES - 1);

   state_t                  state;
   logic [IDX_W-1:0]        cnt;
   logic [IDX_W-1:0]        best_idx;
   logic signed [DW-1:0]    best_score;
   logic                    in_ready_r;
   logic                    out_valid_r;
   logic                    busy_r;
   logic [IDX_W-1:0]        class_idx_r;
   logic [DW-1:0]           class_score_r;

   logic signed [DW-1:0]    din_s;
   logic                    take_new;

   assign din_s    = bus.din;
   // First beat of an image always seeds the running max; later beats need a strict win,
   // so on ties the earlier (lower) index is kept.
   assign take_new = (cnt == '0) || (din_s > best_score);

   assign bus.in_ready    = in_ready_r;
   assign bus.out_valid   = out_valid_r;
   assign bus.busy        = busy_r;
   assign bus.class_idx   = class_idx_r;
   assign bus.class_score = class_score_r;

   always_ff @(posedge clk) begin
      if (!rst) begin
         state         <= IDLE;
         cnt           <= '0;
         best_idx      <= '0;
         best_score    <= '0;
         in_ready_r    <= 1'b0;
         out_valid_r   <= 1'b0;
         busy_r        <= 1'b0;
         class_idx_r   <= '0;
         class_score_r <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (bus.start) begin
                  state      <= COLLECT;
                  cnt        <= '0;
                  in_ready_r <= 1'b1;
                  busy_r     <= 1'b1;
               end
            end

            COLLECT: begin
               // A restart wins over any beat presented in the same cycle.
               if (bus.start) begin
                  cnt <= '0;
               end else if (bus.in_valid) begin
                  if (take_new) begin
                     best_score <= din_s;
                     best_idx   <= cnt;
                  end
                  if (cnt == LAST) begin
                     // Load the result straight from this beat's decision so the
                     // output is final one cycle after the last beat.
                     state         <= DONE;
                     in_ready_r    <= 1'b0;
                     out_valid_r   <= 1'b1;
                     class_idx_r   <= take_new ? cnt : best_idx;
                     class_score_r <= take_new ? bus.din : best_score;
                  end else begin
                     cnt <= cnt + 1'b1;
                  end
               end
            end

            DONE: begin
               if (bus.out_ready) begin
                  state       <= IDLE;
                  out_valid_r <= 1'b0;
                  busy_r      <= 1'b0;
               end
            end

            default: begin
               state       <= IDLE;
               in_ready_r  <= 1'b0;
               out_valid_r <= 1'b0;
               busy_r      <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_mac_argmax.sv
// Bench for mac_argmax: scoreboard of expected (index, score) results pushed when an image is driven.
// Inputs are driven and outputs sampled on the falling clock edge.
module tb_mac_argmax;
   localparam int N  = 10;
   localparam int DW = 22;
   localparam int IW = 4;

   typedef logic signed [DW-1:0] score_t;
   typedef score_t img_t [N];
   typedef struct packed {
      logic [IW-1:0] idx;
      logic [DW-1:0] sc;
   } res_t;

   logic clk = 1'b0;
   logic rst;
   int   total = 0;
   int   bad   = 0;
   res_t exp_q[$];

   always #5 clk = ~clk;

   mac_argmax_if #(.DW(DW), .IDX_W(IW)) ifc ();

   mac_argmax #(.N_CLASSES(N), .DW(DW), .IDX_W(IW)) dut (
      .clk (clk),
      .rst (rst),
      .bus (ifc.slave)
   );

   // Reference argmax: first strictly larger score wins.
   function automatic res_t model(input img_t img);
      res_t r;
      score_t best;
      r.idx = '0;
      best  = img[0];
      for (int i = 1; i < N; i++) begin
         if (img[i] > best) begin
            best  = img[i];
            r.idx = IW'(i);
         end
      end
      r.sc = best;
      return r;
   endfunction

   task automatic tick();
      @(negedge clk);
   endtask

   task automatic do_start();
      ifc.start = 1'b1;
      tick();
      ifc.start = 1'b0;
   endtask

   task automatic do_beat(input score_t s, input int gaps);
      for (int g = 0; g < gaps; g++) begin
         ifc.in_valid = 1'b0;
         tick();
      end
      ifc.in_valid = 1'b1;
      ifc.din      = s;
      tick();
      ifc.in_valid = 1'b0;
   endtask

   task automatic send_image(input img_t img, input bit gappy);
      exp_q.push_back(model(img));
      do_start();
      for (int i = 0; i < N; i++) do_beat(img[i], (gappy && i > 0) ? 1 : 0);
   endtask

   // Waits (bounded) for out_valid, captures the result, then completes the handshake.
   task automatic get_result(output bit ok, output res_t r);
      ok = 1'b0;
      r  = '0;
      for (int c = 0; c < 50 && !ok; c++) begin
         if (ifc.out_valid === 1'b1) begin
            ok    = 1'b1;
            r.idx = ifc.class_idx;
            r.sc  = ifc.class_score;
         end else begin
            tick();
         end
      end
      if (!ok) begin
         total++;
         bad++;
         $display("FAIL result_timeout: out_valid stayed %b, want 1 within 50 cycles", ifc.out_valid);
      end else begin
         ifc.out_ready = 1'b1;
         tick();
         ifc.out_ready = 1'b0;
      end
   endtask

   task automatic test_reset();
      rst = 1'b0;
      repeat (3) tick();
      total++; if (ifc.in_ready !== 1'b0) begin bad++; $display("FAIL reset_in_ready: got %b want 0", ifc.in_ready); end
      total++; if (ifc.out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid: got %b want 0", ifc.out_valid); end
      total++; if (ifc.busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b want 0", ifc.busy); end
      total++; if (ifc.class_idx !== 4'd0) begin bad++; $display("FAIL reset_class_idx: got %0d want 0", ifc.class_idx); end
      total++; if (ifc.class_score !== 22'd0) begin bad++; $display("FAIL reset_class_score: got %h want 0", ifc.class_score); end
      rst = 1'b1;
      tick();
   endtask

   task automatic test_ascending();
      img_t img; bit ok; res_t got, ex;
      for (int i = 0; i < N; i++) img[i] = score_t'(10 * i);
      send_image(img, 1'b0);
      total++; if (ifc.out_valid !== 1'b1) begin bad++; $display("FAIL asc_latency: out_valid got %b want 1 one cycle after last beat", ifc.out_valid); end
      get_result(ok, got);
      ex = exp_q.pop_front();
      if (ok) begin
         total++;
         if (got !== ex) begin bad++; $display("FAIL asc_result: got idx=%0d score=%0d want idx=%0d score=%0d", got.idx, $signed(got.sc), ex.idx, $signed(ex.sc)); end
      end
      total++; if ({ifc.out_valid, ifc.busy} !== 2'b00) begin bad++; $display("FAIL asc_release: out_valid,busy got %b want 00", {ifc.out_valid, ifc.busy}); end
   endtask

   task automatic test_negative();
      img_t img; bit ok; res_t got, ex;
      img = '{-100, -50, -6, -5, -7, -20, -99, -8, -30, -6};
      send_image(img, 1'b0);
      get_result(ok, got);
      ex = exp_q.pop_front();
      if (ok) begin
         total++;
         if (got !== ex) begin bad++; $display("FAIL neg_result: got idx=%0d score=%h want idx=%0d score=%h", got.idx, got.sc, ex.idx, ex.sc); end
         total++;
         if (got.sc !== 22'h3FFFFB) begin bad++; $display("FAIL neg_score_bits: got %h want 3ffffb", got.sc); end
      end
   endtask

   task automatic test_tie();
      img_t img; bit ok; res_t got, ex;
      img = '{0, 0, 7, 0, 0, 0, 7, 0, 0, 0};
      send_image(img, 1'b0);
      get_result(ok, got);
      ex = exp_q.pop_front();
      if (ok) begin
         total++;
         if (got !== ex) begin bad++; $display("FAIL tie_result: got idx=%0d score=%0d want idx=%0d score=%0d", got.idx, $signed(got.sc), ex.idx, $signed(ex.sc)); end
      end
   endtask

   task automatic test_backpressure();
      img_t img; res_t ex; logic [IW+DW+2:0] obs, want;
      img = '{3, 1200, -4, 900, 1199, -2000000, 1200, 50, 0, 11};
      exp_q.push_back(model(img));
      ifc.out_ready = 1'b0;
      do_start();
      total++; if ({ifc.in_ready, ifc.busy} !== 2'b11) begin bad++; $display("FAIL bp_collect_entry: in_ready,busy got %b want 11", {ifc.in_ready, ifc.busy}); end
      for (int i = 0; i < N; i++) do_beat(img[i], (i > 0) ? 1 : 0);
      ex = exp_q.pop_front();
      want = {1'b1, 1'b0, 1'b1, ex.idx, ex.sc};
      for (int c = 0; c < 6; c++) begin
         obs = {ifc.out_valid, ifc.in_ready, ifc.busy, ifc.class_idx, ifc.class_score};
         total++;
         if (obs !== want) begin bad++; $display("FAIL bp_hold_%0d: valid/rdy/busy/idx/score got %h want %h", c, obs, want); end
         ifc.start = (c == 2);
         tick();
         ifc.start = 1'b0;
      end
      ifc.out_ready = 1'b1;
      tick();
      ifc.out_ready = 1'b0;
      total++; if ({ifc.out_valid, ifc.busy} !== 2'b00) begin bad++; $display("FAIL bp_release: out_valid,busy got %b want 00", {ifc.out_valid, ifc.busy}); end
      total++; if ({ifc.class_idx, ifc.class_score} !== {ex.idx, ex.sc}) begin bad++; $display("FAIL bp_result_hold: got idx=%0d score=%0d want idx=%0d score=%0d", ifc.class_idx, $signed(ifc.class_score), ex.idx, $signed(ex.sc)); end
      tick();
      total++; if (ifc.in_ready !== 1'b0) begin bad++; $display("FAIL bp_start_in_done_ignored: in_ready got %b want 0", ifc.in_ready); end
   endtask

   task automatic test_restart();
      img_t img; bit ok; res_t got, ex;
      img = '{3, -2, 40, 1, 0, 39, 12, 2, 41, -9};
      do_start();
      do_beat(score_t'(5), 0);
      do_beat(score_t'(1000), 0);
      do_beat(score_t'(7), 0);
      do_beat(score_t'(8), 0);
      // Restart with a beat in the same cycle: that beat must be dropped.
      ifc.start    = 1'b1;
      ifc.in_valid = 1'b1;
      ifc.din      = score_t'(5000);
      tick();
      ifc.start    = 1'b0;
      ifc.in_valid = 1'b0;
      exp_q.push_back(model(img));
      for (int i = 0; i < N; i++) do_beat(img[i], 0);
      total++; if (ifc.out_valid !== 1'b1) begin bad++; $display("FAIL restart_latency: out_valid got %b want 1", ifc.out_valid); end
      get_result(ok, got);
      ex = exp_q.pop_front();
      if (ok) begin
         total++;
         if (got !== ex) begin bad++; $display("FAIL restart_result: got idx=%0d score=%0d want idx=%0d score=%0d", got.idx, $signed(got.sc), ex.idx, $signed(ex.sc)); end
      end
   endtask

   task automatic test_midreset();
      img_t img; bit ok; res_t got, ex;
      do_start();
      for (int i = 0; i < 6; i++) do_beat(score_t'(500 + i), 0);
      rst          = 1'b0;
      ifc.in_valid = 1'b1;
      ifc.din      = score_t'(9999);
      tick();
      ifc.in_valid = 1'b0;
      total++; if ({ifc.in_ready, ifc.out_valid, ifc.busy} !== 3'b000) begin bad++; $display("FAIL midrst_flags: in_ready,out_valid,busy got %b want 000", {ifc.in_ready, ifc.out_valid, ifc.busy}); end
      total++; if (ifc.class_idx !== 4'd0) begin bad++; $display("FAIL midrst_class_idx: got %0d want 0", ifc.class_idx); end
      total++; if (ifc.class_score !== 22'd0) begin bad++; $display("FAIL midrst_class_score: got %h want 0", ifc.class_score); end
      rst = 1'b1;
      repeat (5) tick();
      total++; if ({ifc.in_ready, ifc.out_valid} !== 2'b00) begin bad++; $display("FAIL midrst_idle: in_ready,out_valid got %b want 00", {ifc.in_ready, ifc.out_valid}); end
      img = '{-1, 2, -3, 4, -5, 66, -7, 8, -9, 10};
      send_image(img, 1'b0);
      get_result(ok, got);
      ex = exp_q.pop_front();
      if (ok) begin
         total++;
         if (got !== ex) begin bad++; $display("FAIL midrst_result: got idx=%0d score=%0d want idx=%0d score=%0d", got.idx, $signed(got.sc), ex.idx, $signed(ex.sc)); end
      end
   endtask

   task automatic test_back_to_back();
      img_t a, b; bit ok; res_t got, ex;
      a = '{2097151, -2097152, 0, 2097151, 5, 5, 5, 5, 5, 5};
      b = '{-2097152, -2097152, -2097152, -2097152, -2097152, -2097152, -2097152, -2097152, -2097152, -2097151};
      for (int k = 0; k < 2; k++) begin
         send_image((k == 0) ? a : b, 1'b0);
         get_result(ok, got);
         ex = exp_q.pop_front();
         if (ok) begin
            total++;
            if (got !== ex) begin bad++; $display("FAIL b2b_result_%0d: got idx=%0d score=%0d want idx=%0d score=%0d", k, got.idx, $signed(got.sc), ex.idx, $signed(ex.sc)); end
         end
      end
      for (int k = 0; k < 3; k++) begin
         img_t r;
         for (int i = 0; i < N; i++) r[i] = score_t'($urandom_range(0, 4000)) - score_t'(2000);
         send_image(r, k[0]);
         get_result(ok, got);
         ex = exp_q.pop_front();
         if (ok) begin
            total++;
            if (got !== ex) begin bad++; $display("FAIL b2b_rand_%0d: got idx=%0d score=%0d want idx=%0d score=%0d", k, got.idx, $signed(got.sc), ex.idx, $signed(ex.sc)); end
         end
      end
   endtask

   initial begin
      rst           = 1'b0;
      ifc.start     = 1'b0;
      ifc.in_valid  = 1'b0;
      ifc.din       = '0;
      ifc.out_ready = 1'b0;
      test_reset();
      test_ascending();
      test_negative();
      test_tie();
      test_backpressure();
      test_restart();
      test_midreset();
      test_back_to_back();
      total++;
      if (exp_q.size() != 0) begin bad++; $display("FAIL scoreboard_drain: %0d results left, want 0", exp_q.size()); end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
